bc_msg_hub: RTL and testbench

Broadcast-message hub that terminates the `bc_msg_out` / `bc_msg_out_valid` / `bc_msg_out_ready` initiator port of every RISC-V block and drives the shared `bc_msg_in` / `bc_msg_in_valid` port back into all of them. It round-robin arbitrates among `CORE_COUNT` cores and forwards one message per cycle. Each accepted message is broadcast to every core's broadcast region after a fixed pipeline latency. It sits at cluster level, between the core array and the scheduler fabric.

---
 rtl/bc_msg_pkg.sv | 16 +
 rtl/bc_rr_arbiter.sv | 52 +++++
 rtl/bc_msg_hub.sv | 128 ++++++++++++
 tb/tb_bc_msg_hub.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_msg_pkg.sv
// Shared constants for the broadcast-message hub: message field layout and
// a helper that derives the word-address width from the total message width.
package bc_msg_pkg;

    localparam int BC_DATA_LSB = 0;
    localparam int BC_DATA_W   = 32;
    localparam int BC_STRB_LSB = 32;
    localparam int BC_STRB_W   = 4;
    localparam int BC_ADDR_LSB = 36;

    // Word address occupies everything above the strobe field.
    function automatic int bc_addr_width(input int msg_width);
        return msg_width - BC_ADDR_LSB;
    endfunction

endpackage

// File: rtl/bc_rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first requester at or above
// the round-robin pointer (wrapping), plus the encoded winner index. The
// pointer moves to one past the winner whenever a grant is issued.
module bc_rr_arbiter #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [IW-1:0] rr_ptr;
    logic [N-1:0]  req_rot;
    logic [IW-1:0] off;
    logic          hit;
    logic [IW:0]   sum;

    // Rotate requests so the pointer sits at bit 0, take the lowest set bit,
    // then add the pointer back modulo N to recover the absolute index.
    always_comb begin
        req_rot = N'({req, req} >> rr_ptr);
        off     = '0;
        hit     = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off = IW'(k);
                hit = 1'b1;
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        grant_idx = sum[IW-1:0];
        grant_any = hit;
        grant     = hit ? (N'(1) << grant_idx) : '0;
    end

    // Pointer advances past the winner on every grant, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (hit) begin
            rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bc_msg_hub.sv
// Broadcast-message hub: round-robin picks one core message per cycle,
// registers it, delays it through OUT_PIPE (0..3) extra stages and broadcasts
// it to all cores for a single cycle. Zero-strobe messages are acked and
// counted as drops but never broadcast.
//
// Handshake: a core transfers when core_msg_valid[i] && core_msg_ready[i] at a
// rising clock edge; the core keeps message and valid stable until then.
// Ready is one-hot or zero, depends only on valids and the round-robin pointer
// (the broadcast side has no backpressure) and is held low during reset.
module bc_msg_hub
    import bc_msg_pkg::*;
#(
    parameter int CORE_COUNT    = 16,
    parameter int MSG_WIDTH     = 46,
    parameter int OUT_PIPE      = 1,
    parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT)
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic [CORE_COUNT*MSG_WIDTH-1:0] core_msg,
    input  logic [CORE_COUNT-1:0]           core_msg_valid,
    output logic [CORE_COUNT-1:0]           core_msg_ready,
    output logic [MSG_WIDTH-1:0]            bc_msg,
    output logic                            bc_msg_valid,
    output logic [CORE_ID_WIDTH-1:0]        bc_msg_src,
    output logic [31:0]                     msg_count,
    output logic [15:0]                     drop_count
);

    localparam int ADDR_W = bc_addr_width(MSG_WIDTH);

    logic [CORE_COUNT-1:0]    grant;
    logic [CORE_ID_WIDTH-1:0] win_idx;
    logic                     win_any;
    logic [MSG_WIDTH-1:0]     win_msg;
    logic [BC_DATA_W-1:0]     win_data;
    logic [BC_STRB_W-1:0]     win_strb;
    logic [ADDR_W-1:0]        win_addr;
    logic                     win_bcast;
    logic                     win_drop;
    logic [31:0]              msg_count_nxt;

    // Stage 0 is the grant register; stages 1..OUT_PIPE form the broadcast chain.
    logic [OUT_PIPE:0]        stg_valid;
    logic [MSG_WIDTH-1:0]     stg_msg [0:OUT_PIPE];
    logic [CORE_ID_WIDTH-1:0] stg_src [0:OUT_PIPE];

    bc_rr_arbiter #(
        .N  (CORE_COUNT),
        .IW (CORE_ID_WIDTH)
    ) u_arb (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .req       (core_msg_valid),
        .grant     (grant),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    // Reset only masks the visible ready; internal state is held by reset anyway.
    assign core_msg_ready = grant & {CORE_COUNT{sys_rst_n}};

    // One-hot AND-OR select of the winning core's message.
    always_comb begin
        win_msg = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (grant[i]) begin
                win_msg = core_msg[i*MSG_WIDTH +: MSG_WIDTH];
            end
        end
    end

    assign win_data  = win_msg[BC_DATA_LSB +: BC_DATA_W];
    assign win_strb  = win_msg[BC_STRB_LSB +: BC_STRB_W];
    assign win_addr  = win_msg[BC_ADDR_LSB +: ADDR_W];
    assign win_bcast = win_any && (win_strb != '0);
    assign win_drop  = win_any && (win_strb == '0);

    // Valid bits of the grant register and broadcast chain; cleared by reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stg_valid <= '0;
        end else begin
            stg_valid[0] <= win_bcast;
            for (int s = 1; s <= OUT_PIPE; s++) begin
                stg_valid[s] <= stg_valid[s-1];
            end
        end
    end

    // Message/source payload follows the valids; no reset needed on data.
    always_ff @(posedge sys_clk) begin
        if (win_any) begin
            stg_msg[0] <= {win_addr, win_strb, win_data};
            stg_src[0] <= win_idx;
        end
        for (int s = 1; s <= OUT_PIPE; s++) begin
            stg_msg[s] <= stg_msg[s-1];
            stg_src[s] <= stg_src[s-1];
        end
    end

    assign bc_msg       = stg_msg[OUT_PIPE];
    assign bc_msg_valid = stg_valid[OUT_PIPE];
    assign bc_msg_src   = stg_src[OUT_PIPE];

    // Broadcast counter wraps naturally at 2^32.
    assign msg_count_nxt = msg_count + 32'(bc_msg_valid);

    // Count each cycle a broadcast is on the output.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            msg_count <= '0;
        end else begin
            msg_count <= msg_count_nxt;
        end
    end

    // Count consumed zero-strobe messages, saturating at all ones.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drop_count <= '0;
        end else if (win_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_bc_msg_hub.sv
// Self-checking bench for bc_msg_hub: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based behavioural model.
module tb_bc_msg_hub;
    import bc_msg_pkg::*;

    localparam int N        = 16;
    localparam int MW       = 46;
    localparam int OUT_PIPE = 1;
    localparam int IW       = 4;
    localparam int AW       = MW - BC_ADDR_LSB;
    localparam int EW       = 32 + IW + MW;

    // ---------------- clock / reset / DUT ----------------
    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [N*MW-1:0] core_msg;
    logic [N-1:0]    core_msg_valid;
    logic [N-1:0]    core_msg_ready;
    logic [MW-1:0]   bc_msg;
    logic            bc_msg_valid;
    logic [IW-1:0]   bc_msg_src;
    logic [31:0]     msg_count;
    logic [15:0]     drop_count;

    always #5 sys_clk = ~sys_clk;

    bc_msg_hub #(
        .CORE_COUNT (N),
        .MSG_WIDTH  (MW),
        .OUT_PIPE   (OUT_PIPE)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .core_msg       (core_msg),
        .core_msg_valid (core_msg_valid),
        .core_msg_ready (core_msg_ready),
        .bc_msg         (bc_msg),
        .bc_msg_valid   (bc_msg_valid),
        .bc_msg_src     (bc_msg_src),
        .msg_count      (msg_count),
        .drop_count     (drop_count)
    );

    // ---------------- model state / scoreboard ----------------
    int            errors = 0;
    int            checks = 0;
    int unsigned   cyc = 0;
    int            m_ptr = 0;
    logic [31:0]   m_msg = '0;
    logic [15:0]   m_drop = '0;
    int            last_win = -1;
    bit            bcast_now = 1'b0;
    bit            force_cnt = 1'b0;
    logic [EW-1:0] exp_q[$];   // {due_cycle, src, msg}

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // First valid core at or after p, scanning upward modulo N.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [MW-1:0] mk_msg(input bit allow_zero);
        logic [MW-1:0] m;
        logic [3:0]    s;
        s = 4'($urandom_range(1, 15));
        if (allow_zero && ($urandom_range(0, 7) == 0)) s = 4'h0;
        m = '0;
        m[BC_DATA_LSB +: BC_DATA_W] = $urandom;
        m[BC_STRB_LSB +: BC_STRB_W] = s;
        m[BC_ADDR_LSB +: AW]        = AW'($urandom);
        return m;
    endfunction

    // Model: advance on each edge out of reset; reset wipes everything in flight.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        int            w;
        logic [MW-1:0] m;
        logic [31:0]   due;
        if (!sys_rst_n) begin
            m_ptr = 0;
            m_msg = '0;
            m_drop = '0;
            last_win = -1;
            exp_q.delete();
        end else begin
            if (force_cnt) m_msg = 32'hFFFF_FFFF;
            else if (bcast_now) m_msg = m_msg + 32'd1;
            w = pick(core_msg_valid, m_ptr);
            last_win = w;
            if (w >= 0) begin
                m = core_msg[w*MW +: MW];
                if (m[BC_STRB_LSB +: BC_STRB_W] != 4'h0) begin
                    due = 32'(cyc + 1 + OUT_PIPE);
                    exp_q.push_back({due, IW'(w), m});
                end else if (m_drop != 16'hFFFF) begin
                    m_drop = m_drop + 16'd1;
                end
                m_ptr = (w + 1) % N;
            end
            cyc++;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge sys_clk) begin
        int            w;
        logic [N-1:0]  er;
        logic [EW-1:0] e;
        bit            ev;
        er = '0;
        ev = 1'b0;
        e  = '0;
        if (sys_rst_n) begin
            w = pick(core_msg_valid, m_ptr);
            if (w >= 0) er[w] = 1'b1;
            if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] == cyc) begin
                ev = 1'b1;
                e  = exp_q.pop_front();
            end
        end
        chk("ready", 64'(core_msg_ready), 64'(er));
        chk("bc_valid", 64'(bc_msg_valid), 64'(ev));
        if (ev) begin
            chk("bc_msg", 64'(bc_msg), 64'(e[MW-1:0]));
            chk("bc_src", 64'(bc_msg_src), 64'(e[MW +: IW]));
        end
        chk("msg_count", 64'(msg_count), 64'(m_msg));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        bcast_now = ev;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b0;
        core_msg_valid = '0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic rand_phase(input int ncyc, input int dens);
        for (int c = 0; c < ncyc; c++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (last_win == i || !core_msg_valid[i]) begin
                    core_msg_valid[i]     = ($urandom_range(0, 99) < dens);
                    core_msg[i*MW +: MW]  = mk_msg(1'b1);
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [MW-1:0] lit;
        core_msg       = '0;
        core_msg_valid = '0;
        sys_rst_n      = 1'b1;
        #1 sys_rst_n   = 1'b0;

        // Reset values, with every core already requesting.
        for (int i = 0; i < N; i++) core_msg[i*MW +: MW] = mk_msg(1'b0);
        core_msg_valid = '1;
        @(negedge sys_clk);
        chk("rst_ready", 64'(core_msg_ready), 64'h0);
        chk("rst_valid", 64'(bc_msg_valid), 64'h0);
        chk("rst_msg_count", 64'(msg_count), 64'h0);
        chk("rst_drop_count", 64'(drop_count), 64'h0);

        // Full contention from reset release: grants 0..15,0..15.
        next_cycle();
        sys_rst_n = 1'b1;
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge sys_clk);
            chk("contention_ready", 64'(core_msg_ready), 64'(1) << (k % N));
            next_cycle();
            core_msg[(k % N)*MW +: MW] = mk_msg(1'b0);
        end
        core_msg_valid = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("contention_count", 64'(msg_count), 64'd32);

        // Single message from core 3 in cycle 5 after reset.
        do_reset();
        repeat (5) next_cycle();
        lit = {10'h010, 4'hF, 32'hDEAD_BEEF};
        core_msg[3*MW +: MW] = lit;
        core_msg_valid = 16'h0008;
        @(negedge sys_clk);
        chk("single_ready", 64'(core_msg_ready), 64'h0008);
        next_cycle();
        core_msg_valid = '0;
        @(negedge sys_clk);
        chk("single_early", 64'(bc_msg_valid), 64'h0);
        next_cycle();
        @(negedge sys_clk);
        chk("single_valid", 64'(bc_msg_valid), 64'h1);
        chk("single_src", 64'(bc_msg_src), 64'h3);
        chk("single_msg", 64'(bc_msg), 64'(lit));
        next_cycle();
        @(negedge sys_clk);
        chk("single_after", 64'(bc_msg_valid), 64'h0);
        chk("single_count", 64'(msg_count), 64'h1);

        // Zero strobe from core 2: acked, counted as a drop, never broadcast.
        next_cycle();
        lit = mk_msg(1'b0);
        lit[BC_STRB_LSB +: BC_STRB_W] = 4'h0;
        core_msg[2*MW +: MW] = lit;
        core_msg_valid = 16'h0004;
        @(negedge sys_clk);
        chk("zero_ready", 64'(core_msg_ready), 64'h0004);
        next_cycle();
        core_msg_valid = '0;
        @(negedge sys_clk);
        chk("zero_drop", 64'(drop_count), 64'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            chk("zero_no_bcast", 64'(bc_msg_valid), 64'h0);
            chk("zero_count", 64'(msg_count), 64'h1);
        end

        // Pointer wrap: park pointer at 15 via core 14, then 15 and 0 contend.
        next_cycle();
        core_msg[14*MW +: MW] = mk_msg(1'b0);
        core_msg_valid = 16'h4000;
        @(negedge sys_clk);
        chk("wrap_park", 64'(core_msg_ready), 64'h4000);
        next_cycle();
        core_msg[15*MW +: MW] = mk_msg(1'b0);
        core_msg[0 +: MW]     = mk_msg(1'b0);
        core_msg_valid = 16'h8001;
        @(negedge sys_clk);
        chk("wrap_g15", 64'(core_msg_ready), 64'h8000);
        next_cycle();
        core_msg[15*MW +: MW] = mk_msg(1'b0);
        @(negedge sys_clk);
        chk("wrap_g0", 64'(core_msg_ready), 64'h0001);
        next_cycle();
        core_msg[0 +: MW] = mk_msg(1'b0);
        @(negedge sys_clk);
        chk("wrap_g15b", 64'(core_msg_ready), 64'h8000);
        next_cycle();
        core_msg_valid = 16'h0001;
        @(negedge sys_clk);
        chk("wrap_g0b", 64'(core_msg_ready), 64'h0001);
        next_cycle();
        core_msg_valid = '0;
        repeat (3) next_cycle();

        // Reset one cycle after accepting a message: it must never appear.
        core_msg[5*MW +: MW] = mk_msg(1'b0);
        core_msg_valid = 16'h0020;
        @(negedge sys_clk);
        chk("flight_ready", 64'(core_msg_ready), 64'h0020);
        next_cycle();
        core_msg_valid = '0;
        #2 sys_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            chk("flight_no_bcast", 64'(bc_msg_valid), 64'h0);
        end
        next_cycle();
        core_msg[0 +: MW]    = mk_msg(1'b0);
        core_msg[7*MW +: MW] = mk_msg(1'b0);
        core_msg_valid = 16'h0081;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("flight_ptr0", 64'(core_msg_ready), 64'h0001);
        chk("flight_count", 64'(msg_count), 64'h0);
        next_cycle();
        core_msg_valid = 16'h0080;
        @(negedge sys_clk);
        chk("flight_g7", 64'(core_msg_ready), 64'h0080);
        next_cycle();
        core_msg_valid = '0;
        repeat (4) next_cycle();

        // Counter wrap: preload all ones, then one broadcast wraps it to zero.
        @(negedge sys_clk);
        force dut.msg_count_nxt = 32'hFFFF_FFFF;
        force_cnt = 1'b1;
        next_cycle();
        release dut.msg_count_nxt;
        force_cnt = 1'b0;
        @(negedge sys_clk);
        chk("wrap_preload", 64'(msg_count), 64'hFFFF_FFFF);
        next_cycle();
        core_msg[1*MW +: MW] = mk_msg(1'b0);
        core_msg_valid = 16'h0002;
        @(negedge sys_clk);
        chk("cwrap_ready", 64'(core_msg_ready), 64'h0002);
        next_cycle();
        core_msg_valid = '0;
        next_cycle();
        @(negedge sys_clk);
        chk("cwrap_valid", 64'(bc_msg_valid), 64'h1);
        chk("cwrap_before", 64'(msg_count), 64'hFFFF_FFFF);
        next_cycle();
        @(negedge sys_clk);
        chk("cwrap_zero", 64'(msg_count), 64'h0);

        // Randomized traffic at several densities.
        rand_phase(600, 30);
        rand_phase(600, 90);
        rand_phase(300, 5);
        next_cycle();
        core_msg_valid = '0;
        repeat (6) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
